// File: rtl/lcd_nibble_responder.sv
// lcd_nibble_responder
// Far-end responder for a 4-bit HD44780-style character LCD bus (E/RS/RW/DB[3:0]).
// Decodes nibble pairs, executes the command subset, keeps a 128-byte DDRAM image
// and reports busy / address counter.
// Build option: define LCD_RESP_READ_EN to enable the busy-flag / address-counter
// read path; without it any RW=1 strobe is flagged as a protocol error.
module lcd_nibble_responder #(
  parameter int CMD_BUSY_CYCLES   = 2000,
  parameter int CLEAR_BUSY_CYCLES = 82000,
  parameter int BUSY_W            = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [3:0] db_in,
  output logic [3:0] db_out,
  output logic       db_oe,
  output logic       busy,
  output logic [6:0] ac,
  output logic       disp_on,
  input  logic [6:0] mon_addr,
  output logic [7:0] mon_data,
  output logic       cmd_strobe,
  output logic [8:0] last_byte,
  output logic       protocol_err
);

  typedef enum logic [1:0] {INIT8, NIB_HI, NIB_LO} mode_t;

  localparam logic [BUSY_W-1:0] LP_CMD_BUSY   = BUSY_W'(CMD_BUSY_CYCLES);
  localparam logic [BUSY_W-1:0] LP_CLEAR_BUSY = BUSY_W'(CLEAR_BUSY_CYCLES);
  localparam logic [BUSY_W-1:0] LP_ONE        = BUSY_W'(1);

  mode_t            r_mode;
  mode_t            w_modeNext;
  logic [1:0]       r_eSync;
  logic [1:0]       r_rsDly;
  logic [1:0]       r_rwDly;
  logic [1:0][3:0]  r_dbDly;
  logic             r_ePrev;
  logic [3:0]       r_hiNib;
  logic [6:0]       r_ac;
  logic             r_id;
  logic             r_dispOn;
  logic             r_filling;
  logic [6:0]       r_fillAddr;
  logic [BUSY_W-1:0] r_busyCnt;
  logic [8:0]       r_lastByte;
  logic             r_cmdStrobe;
  logic             r_err;
  logic [7:0]       r_monData;
  logic [7:0]       r_ddram [128];

  logic             w_eS;
  logic             w_rsS;
  logic             w_rwS;
  logic [3:0]       w_dbS;
  logic             w_fall;
  logic             w_busy;
  logic             w_latchHi;
  logic             w_exec;
  logic             w_errSet;
  logic [7:0]       w_byte;
  logic             w_longCmd;

  // Next address-counter value, skipping the gaps between the two display lines
  function automatic logic [6:0] stepAc(input logic [6:0] a, input logic inc);
    logic [6:0] n;
    if (inc) begin
      if (a == 7'h27)      n = 7'h40;
      else if (a == 7'h67) n = 7'h00;
      else                 n = a + 7'd1;
    end else begin
      if (a == 7'h00)      n = 7'h67;
      else if (a == 7'h40) n = 7'h27;
      else                 n = a - 7'd1;
    end
    return n;
  endfunction

  assign w_eS      = r_eSync[1];
  assign w_rsS     = r_rsDly[1];
  assign w_rwS     = r_rwDly[1];
  assign w_dbS     = r_dbDly[1];
  assign w_fall    = r_ePrev & ~w_eS;
  assign w_busy    = (r_busyCnt != '0);
  assign w_byte    = {r_hiNib, w_dbS};
  assign w_longCmd = ~w_rsS & (w_byte[7:2] == 6'b000000) & (w_byte[1:0] != 2'b00);

  // Synchronize E and carry RS/RW/DB through matching stages so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eSync <= '0;
      r_rsDly <= '0;
      r_rwDly <= '0;
      r_dbDly <= '0;
      r_ePrev <= 1'b0;
    end else begin
      r_eSync <= {r_eSync[0], lcd_e};
      r_rsDly <= {r_rsDly[0], lcd_rs};
      r_rwDly <= {r_rwDly[0], lcd_rw};
      r_dbDly <= {r_dbDly[0], db_in};
      r_ePrev <= w_eS;
    end
  end

  // Mode state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mode <= INIT8;
    else        r_mode <= w_modeNext;
  end

  // Strobe handling: mode transitions, nibble latch/execute decisions, error detection
  always_comb begin
    w_modeNext = r_mode;
    w_latchHi  = 1'b0;
    w_exec     = 1'b0;
    w_errSet   = 1'b0;
    if (w_fall) begin
      if (w_rwS) begin
`ifdef LCD_RESP_READ_EN
        if (r_mode == NIB_HI)      w_modeNext = NIB_LO;
        else if (r_mode == NIB_LO) w_modeNext = NIB_HI;
`else
        w_errSet = 1'b1;
`endif
      end else begin
        case (r_mode)
          INIT8: begin
            if (w_dbS == 4'h2)      w_modeNext = NIB_HI;
            else if (w_dbS != 4'h3) w_errSet   = 1'b1;
          end
          NIB_HI: begin
            if (w_busy) begin
              w_errSet = 1'b1;
            end else begin
              w_latchHi  = 1'b1;
              w_modeNext = NIB_LO;
            end
          end
          NIB_LO: begin
            if (w_busy) begin
              w_errSet = 1'b1;
            end else begin
              w_exec     = 1'b1;
              w_modeNext = NIB_HI;
            end
          end
          default: w_modeNext = INIT8;
        endcase
      end
    end
  end

  // Byte execution, busy countdown and the clear-fill sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hiNib     <= '0;
      r_ac        <= '0;
      r_id        <= 1'b1;
      r_dispOn    <= 1'b0;
      r_filling   <= 1'b0;
      r_fillAddr  <= '0;
      r_busyCnt   <= '0;
      r_lastByte  <= '0;
      r_cmdStrobe <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_cmdStrobe <= w_exec;
      if (w_errSet)  r_err   <= 1'b1;
      if (w_latchHi) r_hiNib <= w_dbS;

      if (w_exec)      r_busyCnt <= w_longCmd ? LP_CLEAR_BUSY : LP_CMD_BUSY;
      else if (w_busy) r_busyCnt <= r_busyCnt - LP_ONE;

      if (r_filling) begin
        r_fillAddr <= r_fillAddr + 7'd1;
        if (r_fillAddr == 7'h7F) begin
          r_filling <= 1'b0;
          r_ac      <= '0;
          r_id      <= 1'b1;
        end
      end

      if (w_exec) begin
        r_lastByte <= {w_rsS, w_byte};
        if (w_rsS) begin
          r_ac <= stepAc(r_ac, r_id);
        end else begin
          casez (w_byte)
            8'b1???????: r_ac <= w_byte[6:0];
            8'b01??????: ;
            8'b001?????: ;
            8'b0001????: if (!w_byte[3]) r_ac <= stepAc(r_ac, w_byte[2]);
            8'b00001???: r_dispOn <= w_byte[2];
            8'b000001??: r_id <= w_byte[1];
            8'b0000001?: r_ac <= '0;
            8'b00000001: begin
              r_filling  <= 1'b1;
              r_fillAddr <= '0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // DDRAM write port; data writes never overlap a fill because the fill runs under busy
  always_ff @(posedge clk) begin
    if (r_filling)             r_ddram[r_fillAddr] <= 8'h20;
    else if (w_exec && w_rsS)  r_ddram[r_ac]       <= w_byte;
  end

  // Monitor port: registered DDRAM lookup, one cycle of latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_monData <= '0;
    else        r_monData <= r_ddram[mon_addr];
  end

`ifdef LCD_RESP_READ_EN
  logic       w_rise;
  logic [3:0] r_dbOut;
  logic       r_dbOe;

  assign w_rise = ~r_ePrev & w_eS;

  // Read path: launch drives busy/AC nibble for the current phase, falling strobe releases
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dbOut <= '0;
      r_dbOe  <= 1'b0;
    end else if (w_rise && w_rwS) begin
      r_dbOe  <= 1'b1;
      r_dbOut <= (r_mode == NIB_LO) ? r_ac[3:0] : {w_busy, r_ac[6:4]};
    end else if (w_fall && w_rwS) begin
      r_dbOe  <= 1'b0;
    end
  end

  assign db_out = r_dbOut;
  assign db_oe  = r_dbOe;
`else
  assign db_out = '0;
  assign db_oe  = 1'b0;
`endif

  assign busy         = w_busy;
  assign ac           = r_ac;
  assign disp_on      = r_dispOn;
  assign mon_data     = r_monData;
  assign cmd_strobe   = r_cmdStrobe;
  assign last_byte    = r_lastByte;
  assign protocol_err = r_err;

endmodule

// File: tb/tb_lcd_nibble_responder.sv
// Testbench for lcd_nibble_responder: drives the LCD pins like a 4-bit writer and
// compares against a behavioural display model kept in this file.
module tb_lcd_nibble_responder;
  localparam int CMD_CYC = 40;
  localparam int CLR_CYC = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       lcd_e = 1'b0;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic [3:0] db_in = 4'h0;
  logic [6:0] mon_addr = 7'h00;
  logic [3:0] db_out;
  logic       db_oe;
  logic       busy;
  logic [6:0] ac;
  logic       disp_on;
  logic [7:0] mon_data;
  logic       cmd_strobe;
  logic [8:0] last_byte;
  logic       protocol_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobeCnt = 0;
  int busyRun = 0;
  int lastRun = 0;

  // Behavioural display model
  int         mMode;
  logic [3:0] mHi;
  logic [6:0] mAc;
  logic       mId;
  logic       mDisp;
  logic       mErr;
  logic [8:0] mLast;
  int         mBusyEnd;
  int         mStrobes;
  logic [7:0] mRam [128];
  bit         mKnown [128];

  lcd_nibble_responder #(
    .CMD_BUSY_CYCLES(CMD_CYC),
    .CLEAR_BUSY_CYCLES(CLR_CYC),
    .BUSY_W(17)
  ) dut (
    .clk(clk), .rst_n(rst_n), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .db_in(db_in), .db_out(db_out), .db_oe(db_oe), .busy(busy), .ac(ac),
    .disp_on(disp_on), .mon_addr(mon_addr), .mon_data(mon_data),
    .cmd_strobe(cmd_strobe), .last_byte(last_byte), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // Cycle count, strobe count and length of the most recent busy window
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (cmd_strobe === 1'b1) strobeCnt++;
    if (busy === 1'b1) busyRun++;
    else begin
      if (busyRun != 0) lastRun = busyRun;
      busyRun = 0;
    end
  end

  function automatic logic [6:0] mStep(input logic [6:0] a, input logic inc);
    int v;
    if (inc) begin
      if (a == 7'h27) return 7'h40;
      if (a == 7'h67) return 7'h00;
      v = (int'(a) + 1) % 128;
    end else begin
      if (a == 7'h00) return 7'h67;
      if (a == 7'h40) return 7'h27;
      v = (int'(a) + 127) % 128;
    end
    return 7'(v);
  endfunction

  task automatic modelReset();
    mMode = 0; mHi = 4'h0; mAc = 7'h00; mId = 1'b1; mDisp = 1'b0;
    mErr = 1'b0; mLast = 9'h000; mBusyEnd = 0;
  endtask

  task automatic modelExec(input logic rs, input logic [7:0] b, input int fall);
    int dur;
    dur = CMD_CYC;
    mLast = {rs, b};
    mStrobes++;
    if (rs) begin
      mRam[mAc] = b; mKnown[mAc] = 1'b1; mAc = mStep(mAc, mId);
    end else if (b >= 8'h80) mAc = b[6:0];
    else if (b >= 8'h20) begin end
    else if (b >= 8'h10) begin if (!b[3]) mAc = mStep(mAc, b[2]); end
    else if (b >= 8'h08) mDisp = b[2];
    else if (b >= 8'h04) mId = b[1];
    else if (b >= 8'h02) begin mAc = 7'h00; dur = CLR_CYC; end
    else if (b == 8'h01) begin
      for (int i = 0; i < 128; i++) begin mRam[i] = 8'h20; mKnown[i] = 1'b1; end
      mAc = 7'h00; mId = 1'b1; dur = CLR_CYC;
    end
    mBusyEnd = fall + 3 + dur;
  endtask

  task automatic modelNibble(input logic rs, input logic rw, input logic [3:0] n, input int fall);
    bit busyNow;
    busyNow = (fall + 2 < mBusyEnd);
    if (rw) begin
`ifdef LCD_RESP_READ_EN
      if (mMode == 1) mMode = 2;
      else if (mMode == 2) mMode = 1;
`else
      mErr = 1'b1;
`endif
    end else if (mMode == 0) begin
      if (n == 4'h2) mMode = 1;
      else if (n != 4'h3) mErr = 1'b1;
    end else if (busyNow) mErr = 1'b1;
    else if (mMode == 1) begin mHi = n; mMode = 2; end
    else begin mMode = 1; modelExec(rs, {mHi, n}, fall); end
  endtask

  task automatic sendNibble(input logic rs, input logic [3:0] n);
    int fall;
    @(negedge clk);
    lcd_rs = rs; lcd_rw = 1'b0; db_in = n;
    repeat (2) @(negedge clk);
    lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    lcd_e = 1'b0; fall = cyc;
    repeat (5) @(negedge clk);
    modelNibble(rs, 1'b0, n, fall);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) begin
      checks++; errors++;
      $display("[TB] FAIL busy_timeout: busy still %b after %0d cycles, required 0", busy, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic sendByte(input logic rs, input logic [7:0] b);
    waitIdle();
    sendNibble(rs, b[7:4]);
    sendNibble(rs, b[3:0]);
  endtask

  task automatic readNibble(output logic [3:0] val, output logic oeHigh, output logic oeAfter,
                            output logic expBusy);
    int fall;
    @(negedge clk);
    lcd_rs = 1'b0; lcd_rw = 1'b1; db_in = 4'hF;
    repeat (2) @(negedge clk);
    expBusy = (cyc + 2 < mBusyEnd);
    lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    val = db_out; oeHigh = db_oe;
    lcd_e = 1'b0; fall = cyc;
    repeat (5) @(negedge clk);
    oeAfter = db_oe;
    modelNibble(1'b0, 1'b1, 4'h0, fall);
    lcd_rw = 1'b0;
  endtask

  task automatic sweepRam(input string tag);
    for (int a = 0; a < 128; a++) begin
      if (mKnown[a]) begin
        @(negedge clk); mon_addr = 7'(a);
        @(negedge clk);
        checks++;
        if (mon_data !== mRam[a]) begin
          errors++;
          $display("[TB] FAIL %s_ddram[%h]: got %h expected %h", tag, a, mon_data, mRam[a]);
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++; if (db_out !== 4'h0) begin errors++; $display("[TB] FAIL rst_db_out: got %h expected 0", db_out); end
    checks++; if (db_oe !== 1'b0) begin errors++; $display("[TB] FAIL rst_db_oe: got %b expected 0", db_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (ac !== 7'h00) begin errors++; $display("[TB] FAIL rst_ac: got %h expected 0", ac); end
    checks++; if (disp_on !== 1'b0) begin errors++; $display("[TB] FAIL rst_disp_on: got %b expected 0", disp_on); end
    checks++; if (mon_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_mon_data: got %h expected 0", mon_data); end
    checks++; if (cmd_strobe !== 1'b0) begin errors++; $display("[TB] FAIL rst_cmd_strobe: got %b expected 0", cmd_strobe); end
    checks++; if (last_byte !== 9'h000) begin errors++; $display("[TB] FAIL rst_last_byte: got %h expected 0", last_byte); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_protocol_err: got %b expected 0", protocol_err); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_init();
    int s0;
    s0 = strobeCnt;
    sendNibble(1'b0, 4'h3); sendNibble(1'b0, 4'h3); sendNibble(1'b0, 4'h3); sendNibble(1'b0, 4'h2);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL init_busy: got %b expected 0", busy); end
    checks++; if (protocol_err !== mErr) begin errors++; $display("[TB] FAIL init_err: got %b expected %b", protocol_err, mErr); end
    checks++; if (strobeCnt != s0) begin errors++; $display("[TB] FAIL init_strobes: got %0d expected %0d", strobeCnt, s0); end
  endtask

  task automatic test_init_cmds();
    sendByte(1'b0, 8'h28); sendByte(1'b0, 8'h06); sendByte(1'b0, 8'h0C);
    waitIdle();
    checks++; if (lastRun != CMD_CYC) begin errors++; $display("[TB] FAIL cmd_busy_len: got %0d expected %0d", lastRun, CMD_CYC); end
    sendByte(1'b0, 8'h01);
    waitIdle();
    checks++; if (lastRun != CLR_CYC) begin errors++; $display("[TB] FAIL clear_busy_len: got %0d expected %0d", lastRun, CLR_CYC); end
    checks++; if (disp_on !== 1'b1) begin errors++; $display("[TB] FAIL init_disp_on: got %b expected 1", disp_on); end
    checks++; if (ac !== 7'h00) begin errors++; $display("[TB] FAIL init_ac: got %h expected 0", ac); end
    checks++; if (last_byte !== mLast) begin errors++; $display("[TB] FAIL init_last: got %h expected %h", last_byte, mLast); end
    checks++; if (strobeCnt != mStrobes) begin errors++; $display("[TB] FAIL init_cmd_count: got %0d expected %0d", strobeCnt, mStrobes); end
    sweepRam("clear");
  endtask

  task automatic test_ac_wrap();
    sendByte(1'b0, 8'hA7); sendByte(1'b1, 8'h48); waitIdle();
    checks++; if (ac !== 7'h40) begin errors++; $display("[TB] FAIL wrap_27: got %h expected 40", ac); end
    @(negedge clk); mon_addr = 7'h27; @(negedge clk);
    checks++; if (mon_data !== 8'h48) begin errors++; $display("[TB] FAIL wrap_data27: got %h expected 48", mon_data); end
    sendByte(1'b0, 8'hE7); sendByte(1'b1, 8'h69); waitIdle();
    checks++; if (ac !== 7'h00) begin errors++; $display("[TB] FAIL wrap_67: got %h expected 00", ac); end
    sendByte(1'b0, 8'h04); sendByte(1'b0, 8'hC0); sendByte(1'b1, 8'h2A); waitIdle();
    checks++; if (ac !== 7'h27) begin errors++; $display("[TB] FAIL wrap_dec40: got %h expected 27", ac); end
    sendByte(1'b0, 8'h80); sendByte(1'b1, 8'h2B); waitIdle();
    checks++; if (ac !== 7'h67) begin errors++; $display("[TB] FAIL wrap_dec00: got %h expected 67", ac); end
    sendByte(1'b0, 8'h06);
  endtask

  task automatic test_random();
    logic       rs;
    logic [7:0] b;
    int         sel;
    for (int k = 0; k < 40; k++) begin
      rs = 1'b0;
      sel = $urandom_range(0, 6);
      case (sel)
        0:       b = {1'b1, 7'($urandom_range(0, 127))};
        1, 5:    begin rs = 1'b1; b = 8'($urandom_range(0, 255)); end
        2:       b = 8'h04 | 8'($urandom_range(0, 3));
        3:       b = 8'h10 | 8'($urandom_range(0, 15));
        4:       b = 8'h08 | 8'($urandom_range(0, 7));
        default: b = 8'($urandom_range(0, 255));
      endcase
      sendByte(rs, b);
      waitIdle();
      checks++; if (ac !== mAc) begin errors++; $display("[TB] FAIL rand_ac(%0d,{%b,%h}): got %h expected %h", k, rs, b, ac, mAc); end
      checks++; if (disp_on !== mDisp) begin errors++; $display("[TB] FAIL rand_disp(%0d): got %b expected %b", k, disp_on, mDisp); end
      checks++; if (last_byte !== mLast) begin errors++; $display("[TB] FAIL rand_last(%0d): got %h expected %h", k, last_byte, mLast); end
    end
    checks++; if (strobeCnt != mStrobes) begin errors++; $display("[TB] FAIL rand_cmd_count: got %0d expected %0d", strobeCnt, mStrobes); end
    checks++; if (protocol_err !== mErr) begin errors++; $display("[TB] FAIL rand_err: got %b expected %b", protocol_err, mErr); end
    sweepRam("rand");
  endtask

  task automatic test_read();
    logic [3:0] v;
    logic       oe, oeA, eb;
    logic [3:0] exp;
`ifdef LCD_RESP_READ_EN
    sendByte(1'b0, 8'h80); sendByte(1'b0, 8'h01);
    readNibble(v, oe, oeA, eb);
    exp = {eb, mAc[6:4]};
    checks++; if (oe !== 1'b1) begin errors++; $display("[TB] FAIL read_oe: got %b expected 1", oe); end
    checks++; if (v !== exp || v !== 4'h8) begin errors++; $display("[TB] FAIL read_busy_hi: got %h expected %h", v, exp); end
    checks++; if (oeA !== 1'b0) begin errors++; $display("[TB] FAIL read_oe_drop: got %b expected 0", oeA); end
    readNibble(v, oe, oeA, eb);
    exp = mAc[3:0];
    checks++; if (v !== exp) begin errors++; $display("[TB] FAIL read_busy_lo: got %h expected %h", v, exp); end
    waitIdle();
    readNibble(v, oe, oeA, eb);
    exp = {eb, mAc[6:4]};
    checks++; if (v !== exp || v !== 4'h0) begin errors++; $display("[TB] FAIL read_idle_hi: got %h expected %h", v, exp); end
    readNibble(v, oe, oeA, eb);
    sendByte(1'b1, 8'h41); waitIdle();
    checks++; if (ac !== mAc) begin errors++; $display("[TB] FAIL read_phase_ac: got %h expected %h", ac, mAc); end
    checks++; if (protocol_err !== mErr) begin errors++; $display("[TB] FAIL read_err: got %b expected %b", protocol_err, mErr); end
`else
    waitIdle();
    checks++; if (protocol_err !== mErr) begin errors++; $display("[TB] FAIL noread_err_pre: got %b expected %b", protocol_err, mErr); end
    sendNibble(1'b0, 4'h8);
    readNibble(v, oe, oeA, eb);
    exp = 4'h0;
    checks++; if (oe !== 1'b0) begin errors++; $display("[TB] FAIL noread_oe: got %b expected 0", oe); end
    checks++; if (v !== exp) begin errors++; $display("[TB] FAIL noread_db: got %h expected %h", v, exp); end
    checks++; if (protocol_err !== mErr || protocol_err !== 1'b1) begin errors++; $display("[TB] FAIL noread_err: got %b expected %b", protocol_err, mErr); end
    sendNibble(1'b0, 4'h5); waitIdle();
    checks++; if (ac !== mAc || ac !== 7'h05) begin errors++; $display("[TB] FAIL noread_phase_ac: got %h expected %h", ac, mAc); end
`endif
  endtask

  task automatic test_busy_violation();
    int s0;
    test_reset();
    test_init();
    sendByte(1'b0, 8'h06); sendByte(1'b0, 8'h90);
    sendByte(1'b1, 8'($urandom_range(8'h21, 8'h7E)));
    s0 = mStrobes;
    repeat (5) @(negedge clk);
    sendNibble(1'b0, 4'hA);
    checks++; if (protocol_err !== mErr || protocol_err !== 1'b1) begin errors++; $display("[TB] FAIL busy_err: got %b expected %b", protocol_err, mErr); end
    sendByte(1'b0, 8'hC3); waitIdle();
    checks++; if (ac !== mAc || ac !== 7'h43) begin errors++; $display("[TB] FAIL busy_pair_ac: got %h expected %h", ac, mAc); end
    checks++; if (last_byte !== 9'h0C3) begin errors++; $display("[TB] FAIL busy_pair_last: got %h expected 0c3", last_byte); end
    checks++; if (mStrobes != s0 + 1) begin errors++; $display("[TB] FAIL busy_model_cmds: got %0d expected %0d", mStrobes, s0 + 1); end
    sweepRam("busy");
  endtask

  task automatic test_reset_mid_clear();
    sendByte(1'b0, 8'hFF); sendByte(1'b1, 8'h55);
    sendByte(1'b0, 8'h80); sendByte(1'b0, 8'h01);
    repeat (48) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (disp_on !== 1'b0) begin errors++; $display("[TB] FAIL mid_disp_on: got %b expected 0", disp_on); end
    checks++; if (mon_data !== 8'h00) begin errors++; $display("[TB] FAIL mid_mon_data: got %h expected 0", mon_data); end
    checks++; if (last_byte !== 9'h000) begin errors++; $display("[TB] FAIL mid_last_byte: got %h expected 0", last_byte); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_err: got %b expected 0", protocol_err); end
    checks++; if (db_oe !== 1'b0) begin errors++; $display("[TB] FAIL mid_db_oe: got %b expected 0", db_oe); end
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    // The fill was cut short: only the low entries were rewritten, the top entry keeps its data
    for (int i = 0; i < 128; i++) mKnown[i] = (i < 40);
    mRam[127] = 8'h55; mKnown[127] = 1'b1;
    sweepRam("abort");
    sendNibble(1'b0, 4'h5);
    checks++; if (protocol_err !== mErr || protocol_err !== 1'b1) begin errors++; $display("[TB] FAIL mid_init8: got %b expected %b", protocol_err, mErr); end
    checks++; if (ac !== 7'h00) begin errors++; $display("[TB] FAIL mid_ac: got %h expected 0", ac); end
  endtask

  initial begin
    mStrobes = 0;
    for (int i = 0; i < 128; i++) begin mRam[i] = 8'h00; mKnown[i] = 1'b0; end
    modelReset();
    test_reset();
    test_init();
    test_init_cmds();
    test_ac_wrap();
    test_random();
    test_read();
    test_busy_violation();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
